vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_pkg.sv | 40 ++++
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_axis_counter.sv | 51 +++++
 rtl/vga_timing_gen.sv | 107 ++++++++++
 tb/tb_vga_timing_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: default 640x480@60 timing, derived totals/sync windows and shared types. Rev 1.0
`default_nettype none

package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_H_TOTAL      = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int DEF_V_TOTAL      = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int DEF_H_SYNC_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
  localparam int DEF_V_SYNC_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic valid;
    logic frame_start;
  } vga_flags_t;

  // Output state that corresponds to sitting on pixel (0,0)
  localparam vga_flags_t FLAGS_AT_ORIGIN = '{hsync: 1'b1, vsync: 1'b1, valid: 1'b1, frame_start: 1'b1};
  localparam vga_flags_t FLAGS_IDLE      = '{hsync: 1'b1, vsync: 1'b1, valid: 1'b0, frame_start: 1'b0};

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: pixel-enable input and raster position/sync outputs of the timing generator. Rev 1.0
`default_nettype none

interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  logic pix_en;
  cnt_t h_cnt;
  cnt_t v_cnt;
  logic hsync;
  logic vsync;
  logic valid;
  logic frame_start;

  modport master (
    input  pix_en,
    output h_cnt, v_cnt, hsync, vsync, valid, frame_start
  );

  modport slave (
    output pix_en,
    input  h_cnt, v_cnt, hsync, vsync, valid, frame_start
  );

endinterface

`default_nettype wire

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: wrapping position counter with terminal-count flag and next-value window compares. Rev 1.0
`default_nettype none

module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL      = DEF_H_TOTAL,
  parameter int ACTIVE     = DEF_H_ACTIVE,
  parameter int SYNC_START = DEF_H_SYNC_START,
  parameter int SYNC_END   = DEF_H_SYNC_END
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output cnt_t cnt,
  output logic tc,
  output logic active_next,
  output logic sync_next
);

  localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
  localparam cnt_t ACT_END = cnt_t'(ACTIVE);
  localparam cnt_t SYN_BEG = cnt_t'(SYNC_START);
  localparam cnt_t SYN_END = cnt_t'(SYNC_END);

  cnt_t cnt_next;

  assign tc = (cnt == LAST);

  always_comb begin
    cnt_next = cnt;
    if (en) begin
      cnt_next = tc ? '0 : cnt + 1'b1;
    end
  end

  // Compares look at the value the counter is about to take so registered flags line up with it
  assign active_next = (cnt_next < ACT_END);
  assign sync_next   = (cnt_next >= SYN_BEG) && (cnt_next < SYN_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: VGA raster counters with registered active-low syncs, valid and frame_start.
// Define VGA_SYNC_DELAY_EN to delay the flags one pixel behind h_cnt/v_cnt. Rev 1.0
`default_nettype none

module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if ((H_TOTAL > CNT_MAX) || (V_TOTAL > CNT_MAX)) begin : g_param_check
    $error("vga_timing_gen: timing totals exceed the 10-bit counter range");
  end

  cnt_t       h_cnt;
  cnt_t       v_cnt;
  logic       h_tc, v_tc;
  logic       h_act_nxt, v_act_nxt;
  logic       h_sync_nxt, v_sync_nxt;
  vga_flags_t flags_d;
  vga_flags_t flags_q;
  vga_flags_t flags_out;

  vga_axis_counter #(
    .TOTAL      (H_TOTAL),
    .ACTIVE     (H_ACTIVE),
    .SYNC_START (H_ACTIVE + H_FP),
    .SYNC_END   (H_ACTIVE + H_FP + H_SYNC)
  ) u_h_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (vga.pix_en),
    .cnt         (h_cnt),
    .tc          (h_tc),
    .active_next (h_act_nxt),
    .sync_next   (h_sync_nxt)
  );

  vga_axis_counter #(
    .TOTAL      (V_TOTAL),
    .ACTIVE     (V_ACTIVE),
    .SYNC_START (V_ACTIVE + V_FP),
    .SYNC_END   (V_ACTIVE + V_FP + V_SYNC)
  ) u_v_axis (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (vga.pix_en & h_tc),
    .cnt         (v_cnt),
    .tc          (v_tc),
    .active_next (v_act_nxt),
    .sync_next   (v_sync_nxt)
  );

  // flags_d is only captured on pix_en cycles, where "next is (0,0)" reduces to both terminal counts
  assign flags_d = '{hsync:       ~h_sync_nxt,
                     vsync:       ~v_sync_nxt,
                     valid:       h_act_nxt & v_act_nxt,
                     frame_start: h_tc & v_tc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= FLAGS_AT_ORIGIN;
    end else if (vga.pix_en) begin
      flags_q <= flags_d;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  vga_flags_t flags_dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_dly <= FLAGS_IDLE;
    end else if (vga.pix_en) begin
      flags_dly <= flags_q;
    end
  end

  assign flags_out = flags_dly;
`else
  assign flags_out = flags_q;
`endif

  assign vga.h_cnt       = h_cnt;
  assign vga.v_cnt       = v_cnt;
  assign vga.hsync       = flags_out.hsync;
  assign vga.vsync       = flags_out.vsync;
  assign vga.valid       = flags_out.valid;
  assign vga.frame_start = flags_out.frame_start;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: scoreboard bench driving a default-timing and a shrunken-timing vga_timing_gen in lockstep.
`default_nettype none

module tb_vga_timing_gen;

  localparam int SHA = 8, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVA = 6, SVF = 1, SVS = 2, SVB = 2;
  localparam int SHT = SHA + SHF + SHS + SHB;
  localparam int SVT = SVA + SVF + SVS + SVB;
  localparam int SFRAME = SHT * SVT;
  localparam int DHT = 800, DVT = 525;
`ifdef VGA_SYNC_DELAY_EN
  localparam int DLY = 1;
`else
  localparam int DLY = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #20 clk = ~clk;

  vga_timing_gen_if dif ();
  vga_timing_gen_if sif ();

  vga_timing_gen u_dflt (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (dif)
  );

  vga_timing_gen #(
    .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
    .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB)
  ) u_small (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (sif)
  );

  logic [23:0] d_obs, s_obs;
  assign d_obs = {dif.h_cnt, dif.v_cnt, dif.hsync, dif.vsync, dif.valid, dif.frame_start};
  assign s_obs = {sif.h_cnt, sif.v_cnt, sif.hsync, sif.vsync, sif.valid, sif.frame_start};

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [23:0] qd[$];
  logic [23:0] qs[$];

  int dh, dv, sh, sv;
  logic [3:0] ddly, sdly;

  bit   mon_on;
  int   mult;
  int   s_last_fs, s_vcnt, d_last_h0, d_hs_run, s_vs_run;
  logic p_sfs, p_dhs, p_svs;
  logic [9:0] p_dh;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // {hsync, vsync, valid, frame_start} straight from the raster position
  function automatic logic [3:0] flags_at(input int h, input int v, input int ha, input int hf,
                                          input int hs, input int va, input int vf, input int vs);
    logic hsn, vsn, val, fs;
    hsn = !((h >= ha + hf) && (h < ha + hf + hs));
    vsn = !((v >= va + vf) && (v < va + vf + vs));
    val = (h < ha) && (v < va);
    fs  = (h == 0) && (v == 0);
    return {hsn, vsn, val, fs};
  endfunction

  function automatic logic [3:0] d_flags();
    return flags_at(dh, dv, 640, 16, 96, 480, 10, 2);
  endfunction

  function automatic logic [3:0] s_flags();
    return flags_at(sh, sv, SHA, SHF, SHS, SVA, SVF, SVS);
  endfunction

  function automatic logic [23:0] d_cur();
    return {10'(dh), 10'(dv), (DLY != 0) ? ddly : d_flags()};
  endfunction

  function automatic logic [23:0] s_cur();
    return {10'(sh), 10'(sv), (DLY != 0) ? sdly : s_flags()};
  endfunction

  task automatic model_reset();
    dh = 0; dv = 0; sh = 0; sv = 0;
    ddly = 4'b1100; sdly = 4'b1100;
    qd.delete(); qs.delete();
  endtask

  task automatic mon_reset(input bit on, input int m);
    mon_on = on; mult = m;
    s_last_fs = -1; s_vcnt = 0; d_last_h0 = -1; d_hs_run = -1; s_vs_run = -1;
    p_sfs = sif.frame_start; p_dhs = dif.hsync; p_svs = sif.vsync; p_dh = dif.h_cnt;
  endtask

  task automatic monitor(input logic en);
    if (mon_on) begin
      if (sif.frame_start && !p_sfs) begin
        if (s_last_fs >= 0) begin
          check("fs_period", cyc - s_last_fs, SFRAME * mult);
          check("valid_per_frame", s_vcnt, SHA * SVA);
        end
        s_last_fs = cyc; s_vcnt = 0;
      end
      if (en && sif.valid) s_vcnt++;

      if (!dif.hsync && p_dhs) begin
        d_hs_run = 0;
        check("hsync_start_h", dif.h_cnt, 656 + DLY);
      end
      if (!dif.hsync && d_hs_run >= 0) d_hs_run++;
      if (dif.hsync && !p_dhs && d_hs_run >= 0) check("hsync_width", d_hs_run, 96 * mult);

      if (!sif.vsync && p_svs) begin
        s_vs_run = 0;
        check("vsync_start_vh", {sif.v_cnt, sif.h_cnt}, {10'(SVA + SVF), 10'(DLY)});
      end
      if (!sif.vsync && s_vs_run >= 0) s_vs_run++;
      if (sif.vsync && !p_svs && s_vs_run >= 0) check("vsync_width", s_vs_run, SVS * SHT * mult);

      if (dif.h_cnt == 10'd0 && p_dh != 10'd0) begin
        if (d_last_h0 >= 0) check("h_period", cyc - d_last_h0, DHT * mult);
        d_last_h0 = cyc;
      end
    end
    p_sfs = sif.frame_start; p_dhs = dif.hsync; p_svs = sif.vsync; p_dh = dif.h_cnt;
  endtask

  // Drive one cycle of pix_en, predict the post-edge state, then score it on the next falling edge
  task automatic step(input logic en);
    logic [23:0] e;
    dif.pix_en = en;
    sif.pix_en = en;
    if (en) begin
      ddly = d_flags();
      sdly = s_flags();
      if (dh == DHT - 1) begin dh = 0; dv = (dv == DVT - 1) ? 0 : dv + 1; end
      else dh++;
      if (sh == SHT - 1) begin sh = 0; sv = (sv == SVT - 1) ? 0 : sv + 1; end
      else sh++;
    end
    qd.push_back(d_cur());
    qs.push_back(s_cur());
    @(negedge clk);
    cyc++;
    e = qd.pop_front();
    check("dflt_state", d_obs, e);
    e = qs.pop_front();
    check("small_state", s_obs, e);
    monitor(en);
  endtask

  task automatic check_reset_state(input string tag);
    logic [23:0] rv;
    rv = {20'd0, (DLY != 0) ? 4'b1100 : 4'b1111};
    check({tag, "_dflt"}, d_obs, rv);
    check({tag, "_small"}, s_obs, rv);
  endtask

  initial begin
    int guard;
    dif.pix_en = 1'b0;
    sif.pix_en = 1'b0;
    mon_on = 1'b0; mult = 1;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("por");
    rst_n = 1'b1;
    #1 check_reset_state("por_release");
    mon_reset(1'b1, 1);

    for (int i = 0; i < 1800; i++) step(1'b1);

    mon_reset(1'b1, 2);
    for (int i = 0; i < 1000; i++) step(1'(i % 2 == 0));

    mon_reset(1'b0, 1);
    for (int i = 0; i < 300; i++) step(1'($urandom_range(0, 1)));

    guard = 0;
    while (!(sh == 5 && sv == 3) && guard < 400) begin
      step(1'b1);
      guard++;
    end
    check("reach_mid_frame", {10'(sh), 10'(sv)}, {10'd5, 10'd3});

    #2 rst_n = 1'b0;
    #1 check_reset_state("mid_reset");
    model_reset();
    @(negedge clk);
    check_reset_state("mid_reset_held");
    rst_n = 1'b1;
    #1 check_reset_state("mid_release");
    mon_reset(1'b1, 1);
    for (int i = 0; i < 400; i++) step(1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
